// File: rtl/af_output_requantizer.sv
// Output stage for adaptive_filter. Signed samples are rounded half toward
// +inf, saturated to a narrower format and buffered in a FWFT FIFO with a
// valid/ready master port. Saturation and overflow statistics are kept.
module af_output_requantizer #(
  parameter int IN_WIDTH   = 14,
  parameter int IN_FRAC    = 6,
  parameter int OUT_WIDTH  = 8,
  parameter int OUT_FRAC   = 2,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                            clk,
  input  logic                            srst,
  input  logic [IN_WIDTH-1:0]             s_tdata,
  input  logic                            s_tvalid,
  output logic [OUT_WIDTH-1:0]            m_tdata,
  output logic                            m_tvalid,
  input  logic                            m_tready,
  input  logic                            clr_stats,
  output logic [15:0]                     sat_cnt,
  output logic [15:0]                     drop_cnt,
  output logic                            ovf_sticky,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level
);

  localparam int SHIFT = IN_FRAC - OUT_FRAC;
  localparam int SW    = IN_WIDTH + 1;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int LW    = AW + 1;

  localparam logic signed [SW-1:0] RND  = SW'((2 ** SHIFT) / 2);
  localparam logic signed [SW-1:0] QMAX = SW'((2 ** (OUT_WIDTH - 1)) - 1);
  localparam logic signed [SW-1:0] QMIN = -(SW'(2 ** (OUT_WIDTH - 1)));

  if (SHIFT < 0) begin : g_bad_shift
    $error("af_output_requantizer: IN_FRAC must be >= OUT_FRAC");
  end
  if (OUT_WIDTH > IN_WIDTH) begin : g_bad_width
    $error("af_output_requantizer: OUT_WIDTH must be <= IN_WIDTH");
  end
  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("af_output_requantizer: FIFO_DEPTH must be a power of two >= 2");
  end

  logic signed [SW-1:0]   sum1;
  logic                   v1;
  logic signed [SW-1:0]   q;
  logic [OUT_WIDTH-1:0]   qsat;
  logic                   sat_now;
  logic [OUT_WIDTH-1:0]   d2;
  logic                   sat2;
  logic                   v2;

  logic [OUT_WIDTH-1:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr;
  logic [AW-1:0]          rd_ptr;
  logic [LW-1:0]          level;
  logic                   full;
  logic                   pop;
  logic                   push;
  logic                   drop;

  // Stage 1: sign-extend one bit and add the rounding offset
  always_ff @(posedge clk) begin
    if (srst) begin
      v1   <= 1'b0;
      sum1 <= '0;
    end else begin
      v1 <= s_tvalid;
      if (s_tvalid) begin
        sum1 <= {s_tdata[IN_WIDTH-1], s_tdata} + RND;
      end
    end
  end

  // Arithmetic shift to the output scale and clamp to the output range
  always_comb begin
    q       = sum1 >>> SHIFT;
    sat_now = 1'b0;
    qsat    = q[OUT_WIDTH-1:0];
    if (q > QMAX) begin
      qsat    = QMAX[OUT_WIDTH-1:0];
      sat_now = 1'b1;
    end else if (q < QMIN) begin
      qsat    = QMIN[OUT_WIDTH-1:0];
      sat_now = 1'b1;
    end
  end

  // Stage 2: register the requantized word and its saturation flag
  always_ff @(posedge clk) begin
    if (srst) begin
      v2   <= 1'b0;
      d2   <= '0;
      sat2 <= 1'b0;
    end else begin
      v2 <= v1;
      if (v1) begin
        d2   <= qsat;
        sat2 <= sat_now;
      end
    end
  end

  // A pop on the same edge frees the slot, so a full FIFO can still accept
  always_comb begin
    full = (level == LW'(FIFO_DEPTH));
    pop  = m_tvalid & m_tready;
    push = v2 & (~full | pop);
    drop = v2 & full & ~pop;
  end

  // FIFO storage; contents need no reset because level gates visibility
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= d2;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // Head word falls through; forced to zero while empty
  always_comb begin
    m_tvalid   = (level != '0);
    m_tdata    = m_tvalid ? mem[rd_ptr] : '0;
    fifo_level = level;
  end

  // Statistics: clear wins over increment, counters stick at all-ones
  always_ff @(posedge clk) begin
    if (srst || clr_stats) begin
      sat_cnt    <= '0;
      drop_cnt   <= '0;
      ovf_sticky <= 1'b0;
    end else begin
      if (push && sat2 && (sat_cnt != '1)) begin
        sat_cnt <= sat_cnt + 16'd1;
      end
      if (drop && (drop_cnt != '1)) begin
        drop_cnt <= drop_cnt + 16'd1;
      end
      if (drop) begin
        ovf_sticky <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_af_output_requantizer.sv
// Bench for af_output_requantizer with default Q8.6 -> Q6.2 parameters.
module tb_af_output_requantizer;

  logic        clk = 1'b0;
  logic        srst;
  logic [13:0] s_tdata;
  logic        s_tvalid;
  logic [7:0]  m_tdata;
  logic        m_tvalid;
  logic        m_tready;
  logic        clr_stats;
  logic [15:0] sat_cnt;
  logic [15:0] drop_cnt;
  logic        ovf_sticky;
  logic [3:0]  fifo_level;

  af_output_requantizer #(
    .IN_WIDTH  (14),
    .IN_FRAC   (6),
    .OUT_WIDTH (8),
    .OUT_FRAC  (2),
    .FIFO_DEPTH(8)
  ) dut (
    .clk       (clk),
    .srst      (srst),
    .s_tdata   (s_tdata),
    .s_tvalid  (s_tvalid),
    .m_tdata   (m_tdata),
    .m_tvalid  (m_tvalid),
    .m_tready  (m_tready),
    .clr_stats (clr_stats),
    .sat_cnt   (sat_cnt),
    .drop_cnt  (drop_cnt),
    .ovf_sticky(ovf_sticky),
    .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [13:0] din;
    logic [7:0]  exp;
    bit          sat;
    bit          gap;
  } vec_t;

  vec_t       tbl[14];
  int         tests = 0;
  int         fails = 0;
  logic [7:0] exp_q[$];
  bit         mon_en = 1'b0;
  int         cyc = 0;
  int         first_vld_cyc = -1;
  int         nsat = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: compare each transferred word against the queue head
  always @(negedge clk) begin
    if (mon_en && m_tvalid && m_tready) begin
      if (first_vld_cyc < 0) first_vld_cyc = cyc;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL out_unexpected: got %0h expected no output", m_tdata);
      end else begin
        chk("out_data", 32'(m_tdata), 32'(exp_q.pop_front()));
      end
    end
  end

  function automatic logic [7:0] model(input logic [13:0] d, output bit s);
    int x;
    int q;
    x = int'($signed(d));
    q = $rtoi($floor(real'(x) / 16.0 + 0.5));
    s = 1'b0;
    if (q > 127) begin
      q = 127;
      s = 1'b1;
    end else if (q < -128) begin
      q = -128;
      s = 1'b1;
    end
    return q[7:0];
  endfunction

  task automatic drive(input logic v, input logic [13:0] d);
    s_tvalid = v;
    s_tdata  = d;
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_left", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
    chk("tvalid_idle", 32'(m_tvalid), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  cap_cyc;
    bit  s;
    logic [13:0] d;
    logic v;

    srst = 1'b1; s_tvalid = 1'b0; s_tdata = '0; m_tready = 1'b1; clr_stats = 1'b0;
    tbl = '{
      '{14'h0018, 8'h02, 1'b0, 1'b0},
      '{14'h3FE8, 8'hFF, 1'b0, 1'b0},
      '{14'h3FF8, 8'h00, 1'b0, 1'b0},
      '{14'h0008, 8'h01, 1'b0, 1'b0},
      '{14'h0800, 8'h7F, 1'b1, 1'b0},
      '{14'h2000, 8'h80, 1'b1, 1'b0},
      '{14'h1FFF, 8'h7F, 1'b1, 1'b1},
      '{14'h07F0, 8'h7F, 1'b0, 1'b0},
      '{14'h3808, 8'h81, 1'b0, 1'b0},
      '{14'h3800, 8'h80, 1'b0, 1'b1},
      '{14'h0808, 8'h7F, 1'b1, 1'b0},
      '{14'h37F0, 8'h80, 1'b1, 1'b0},
      '{14'h0007, 8'h00, 1'b0, 1'b1},
      '{14'h3FF7, 8'hFF, 1'b0, 1'b0}
    };

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_level",  32'(fifo_level), 32'd0);
    chk("rst_tvalid", 32'(m_tvalid),   32'd0);
    chk("rst_tdata",  32'(m_tdata),    32'd0);
    chk("rst_sat",    32'(sat_cnt),    32'd0);
    chk("rst_drop",   32'(drop_cnt),   32'd0);
    chk("rst_ovf",    32'(ovf_sticky), 32'd0);
    srst = 1'b0;
    mon_en = 1'b1;

    // Table-driven rounding/saturation vectors with occasional bubbles
    first_vld_cyc = -1;
    cap_cyc = 0;
    for (int i = 0; i < 14; i++) begin
      if (tbl[i].gap) drive(1'b0, '0);
      exp_q.push_back(tbl[i].exp);
      if (tbl[i].sat) nsat++;
      drive(1'b1, tbl[i].din);
      if (i == 0) cap_cyc = cyc;
    end
    wait_drain();
    chk("latency", 32'(first_vld_cyc - cap_cyc + 1), 32'd3);
    chk("tbl_sat_cnt",  32'(sat_cnt),  32'(nsat));
    chk("tbl_drop_cnt", 32'(drop_cnt), 32'd0);

    // Random stream with random backpressure, never allowed to fill
    for (int i = 0; i < 300; i++) begin
      v = 1'($urandom_range(0, 1));
      d = ($urandom_range(0, 1) == 0) ? 14'($urandom) : 14'($urandom_range(0, 4095)) - 14'd2048;
      m_tready = (fifo_level >= 4'd5) ? 1'b1 : ($urandom_range(0, 3) != 0);
      if (v) begin
        exp_q.push_back(model(d, s));
        if (s) nsat++;
      end
      drive(v, d);
    end
    m_tready = 1'b1;
    wait_drain();
    chk("rnd_sat_cnt",  32'(sat_cnt),  32'(nsat));
    chk("rnd_drop_cnt", 32'(drop_cnt), 32'd0);

    // Overflow: 12 samples into a stalled FIFO, then drain 1..8
    m_tready = 1'b0;
    for (int i = 1; i <= 12; i++) drive(1'b1, 14'(i << 4));
    drive(1'b0, '0);
    drive(1'b0, '0);
    chk("ovf_level",  32'(fifo_level), 32'd8);
    chk("ovf_drop",   32'(drop_cnt),   32'd4);
    chk("ovf_sticky", 32'(ovf_sticky), 32'd1);
    chk("ovf_sat",    32'(sat_cnt),    32'(nsat));
    mon_en = 1'b0;
    m_tready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      chk("drain_tvalid", 32'(m_tvalid), 32'd1);
      chk("drain_data",   32'(m_tdata),  32'(i));
    end
    @(negedge clk);
    chk("drain_empty", 32'(m_tvalid), 32'd0);
    mon_en = 1'b1;

    // clr_stats on the same edge as a saturating write
    @(posedge clk);
    #1;
    exp_q.push_back(8'h7F);
    drive(1'b1, 14'h0800);
    drive(1'b0, '0);
    clr_stats = 1'b1;
    drive(1'b0, '0);
    clr_stats = 1'b0;
    chk("clr_sat",  32'(sat_cnt),    32'd0);
    chk("clr_drop", 32'(drop_cnt),   32'd0);
    chk("clr_ovf",  32'(ovf_sticky), 32'd0);
    wait_drain();
    chk("clr_sat_hold", 32'(sat_cnt), 32'd0);

    // Full FIFO with simultaneous pop and push: no drops, level stays 8
    m_tready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      m_tready = (i >= 10);
      exp_q.push_back(8'(40 + i));
      drive(1'b1, 14'((40 + i) << 4));
      if (i >= 10) chk("full_level", 32'(fifo_level), 32'd8);
    end
    chk("full_drop", 32'(drop_cnt), 32'd0);
    wait_drain();

    // Synchronous reset mid-stream with FIFO at level 5
    m_tready = 1'b0;
    drive(1'b1, 14'h0800);
    for (int i = 1; i <= 4; i++) drive(1'b1, 14'(i << 4));
    drive(1'b0, '0);
    drive(1'b0, '0);
    chk("mid_level", 32'(fifo_level), 32'd5);
    chk("mid_sat",   32'(sat_cnt),    32'd1);
    mon_en = 1'b0;
    srst = 1'b1;
    for (int i = 0; i < 3; i++) drive(1'b1, 14'h0100);
    srst = 1'b0;
    chk("srst_level",  32'(fifo_level), 32'd0);
    chk("srst_tvalid", 32'(m_tvalid),   32'd0);
    chk("srst_tdata",  32'(m_tdata),    32'd0);
    chk("srst_sat",    32'(sat_cnt),    32'd0);
    repeat (3) drive(1'b0, '0);
    chk("srst_noleak", 32'(fifo_level), 32'd0);
    exp_q.delete();
    mon_en = 1'b1;
    m_tready = 1'b1;
    exp_q.push_back(8'h05);
    drive(1'b1, 14'h0050);
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
